// File: rtl/seq_arith_unit.sv
// Sequential arithmetic unit: single-cycle add/sub/shift and multi-cycle
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module seq_arith_unit #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] result,
  output logic           flag,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] result_q, result_d;
  logic           flag_q, flag_d;

  // Single-cycle datapath works on the live inputs at the acceptance edge.
  logic [N:0]     add_sum;
  logic [N:0]     sub_diff;
  logic [2*N-1:0] shl_val;
  logic [2*N-1:0] shr_val;

  // Iterative datapath works on the captured operands and the accumulator.
  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     div_rem_sh;
  logic           div_ge;
  logic [N-1:0]   div_diff;
  logic [2*N-1:0] div_next;
  logic [2*N-1:0] iter_next;

  // Combinational arithmetic for both the one-shot ops and one iteration step.
  always_comb begin
    add_sum    = {1'b0, x} + {1'b0, y};
    sub_diff   = {1'b0, x} - {1'b0, y};
    shl_val    = {x, y} << 1;
    shr_val    = {x, y} >> 1;

    mul_sum    = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, x_q} : {(N+1){1'b0}});
    mul_next   = {mul_sum, acc_q[N-1:1]};

    div_rem_sh = acc_q[2*N-1:N-1];
    div_ge     = (div_rem_sh >= {1'b0, y_q});
    // When the trial subtraction succeeds the difference is below y, so N bits suffice.
    div_diff   = div_rem_sh[N-1:0] - y_q;
    div_next   = div_ge ? {div_diff, acc_q[N-2:0], 1'b1}
                        : {acc_q[2*N-2:0], 1'b0};

    iter_next  = (op_q == OP_DIV) ? div_next : mul_next;
  end

  // Next-state and datapath register control; every _d defaults to hold.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          x_d   = x;
          y_d   = y;
          cnt_d = '0;
          case (op)
            OP_ADD: begin
              state_d  = DONE;
              result_d = {{(N-1){1'b0}}, add_sum};
              flag_d   = add_sum[N];
            end
            OP_SUB: begin
              state_d  = DONE;
              result_d = {{(N-1){1'b0}}, sub_diff};
              flag_d   = sub_diff[N];
            end
            OP_SHL: begin
              state_d  = DONE;
              result_d = shl_val;
              flag_d   = x[N-1];
            end
            OP_SHR: begin
              state_d  = DONE;
              result_d = shr_val;
              flag_d   = y[0];
            end
            OP_MUL: begin
              state_d = RUN;
              acc_d   = {{N{1'b0}}, y};
            end
            OP_DIV: begin
              if (y == '0) begin
                // Divide by zero short-circuits: all-ones quotient, dividend as remainder.
                state_d  = DONE;
                result_d = {x, {N{1'b1}}};
                flag_d   = 1'b1;
              end else begin
                state_d = RUN;
                acc_d   = {{N{1'b0}}, x};
              end
            end
            default: begin
              state_d  = DONE;
              result_d = '0;
              flag_d   = 1'b1;
            end
          endcase
        end
      end

      RUN: begin
        acc_d = iter_next;
        cnt_d = cnt_q + CW'(1);
        // Last iteration: publish the finished value on the edge entering DONE.
        if (cnt_q == CW'(N - 1)) begin
          state_d  = DONE;
          result_d = iter_next;
          flag_d   = (op_q == OP_DIV) ? 1'b0 : (|iter_next[2*N-1:N]);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign result = result_q;
  assign flag   = flag_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit (N=8): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_seq_arith_unit;

  localparam int N = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2:0]     op;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic [2*N-1:0] result;
  logic           flag;
  logic           busy;
  logic           done;

  seq_arith_unit #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .x      (x),
    .y      (y),
    .result (result),
    .flag   (flag),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    logic [15:0] r;
    logic        f;
    int          c;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_seen++;
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none (result=0x%h)", cyc, result);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.nm, "_result"}, 32'(result), 32'(mon_e.r));
        check({mon_e.nm, "_flag"}, 32'(flag), 32'(mon_e.f));
        check({mon_e.nm, "_cycle"}, 32'(cyc), 32'(mon_e.c));
        $display("txn %-10s result=0x%h flag=%b cycle=%0d", mon_e.nm, result, flag, cyc);
      end
    end
  end

  // Wait until nothing is pending and the unit is idle, bounded.
  task automatic wait_quiet();
    int n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_quiet_timeout: got busy=%b pending=%0d, expected idle", busy, q.size());
      q.delete();
    end
  endtask

  // Issue one operation; returns 1ns after the acceptance edge with the
  // inputs scrambled so the DUT must rely on its captured copies.
  task automatic issue(input string nm, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] r, input logic f,
                       input int lat);
    exp_t e;
    wait_quiet();
    op    = o;
    x     = a;
    y     = b;
    start = 1'b1;
    e.r = r; e.f = f; e.c = cyc + lat; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = 8'($urandom);
    y     = 8'($urandom);
    op    = 3'($urandom);
  endtask

  // Hold start high for a number of edges with fixed operands.
  task automatic hold_start(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                            input int edges);
    op    = o;
    x     = a;
    y     = b;
    start = 1'b1;
    repeat (edges) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   s0;
    int   d0;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    x     = '0;
    y     = '0;

    // Reset with start asserted: nothing may be accepted while rst_n is low.
    repeat (2) @(posedge clk);
    #1;
    op = 3'b000; x = 8'd1; y = 8'd1; start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_result", 32'(result), 32'h0);
    check("rst_flag", 32'(flag), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    start = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add 200+100: latency 1, busy for exactly one cycle.
    issue("add_carry", 3'b000, 8'd200, 8'd100, 16'h012C, 1'b1, 1);
    check("add_busy_dn", 32'(busy), 32'h1);
    @(posedge clk);
    #1;
    check("add_busy_idle", 32'(busy), 32'h0);

    issue("add_small", 3'b000, 8'd1,    8'd2,    16'h0003, 1'b0, 1);
    issue("sub_borrow",3'b001, 8'd3,    8'd5,    16'h01FE, 1'b1, 1);
    issue("sub_plain", 3'b001, 8'd5,    8'd3,    16'h0002, 1'b0, 1);
    // {0x81,0x03} >> 1 = 0x4081, bit shifted out is y[0] = 1.
    issue("shr1",      3'b011, 8'h81,   8'h03,   16'h4081, 1'b1, 1);
    // {0x81,0x03} << 1 = 0x0206, bit shifted out is x[7] = 1.
    issue("shl1",      3'b010, 8'h81,   8'h03,   16'h0206, 1'b1, 1);

    // mul 200*3 = 600, start pulsed during RUN must be ignored.
    issue("mul_ovf",   3'b100, 8'd200,  8'd3,    16'h0258, 1'b1, 9);
    @(posedge clk);
    #1;
    hold_start(3'b000, 8'd7, 8'd7, 3);

    issue("mul_fit",   3'b100, 8'd15,   8'd17,   16'h00FF, 1'b0, 9);
    issue("mul_max",   3'b100, 8'd255,  8'd255,  16'hFE01, 1'b1, 9);
    issue("div_7",     3'b101, 8'd200,  8'd7,    16'h041C, 1'b0, 9);
    issue("div_zero",  3'b101, 8'd9,    8'd0,    16'h09FF, 1'b1, 1);
    issue("div_one",   3'b101, 8'd255,  8'd1,    16'h00FF, 1'b0, 9);
    issue("ill_110",   3'b110, 8'd12,   8'd34,   16'h0000, 1'b1, 1);
    issue("ill_111",   3'b111, 8'd56,   8'd78,   16'h0000, 1'b1, 1);
    issue("div_small", 3'b101, 8'd5,    8'd9,    16'h0500, 1'b0, 9);

    // Result and flag hold through IDLE.
    wait_quiet();
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", 32'(result), 32'h0500);
    check("hold_flag", 32'(flag), 32'h0);

    // Back-to-back adds with start held: accepted every other edge.
    wait_quiet();
    s0 = cyc;
    e.r = 16'h001E; e.f = 1'b0; e.nm = "b2b_add";
    e.c = s0 + 1; q.push_back(e);
    e.c = s0 + 3; q.push_back(e);
    e.c = s0 + 5; q.push_back(e);
    hold_start(3'b000, 8'd10, 8'd20, 5);

    // Back-to-back multiplies with start held: done pulses 10 cycles apart.
    wait_quiet();
    s0 = cyc;
    e.r = 16'h00C8; e.f = 1'b0; e.nm = "b2b_mul";
    e.c = s0 + 9;  q.push_back(e);
    e.c = s0 + 19; q.push_back(e);
    hold_start(3'b100, 8'd20, 8'd10, 11);

    // Reset mid-multiply (fourth RUN cycle): outputs clear at once, no done follows.
    issue("mul_abort", 3'b100, 8'd200, 8'd3, 16'h0258, 1'b1, 9);
    repeat (3) @(posedge clk);
    #2;
    q.delete();
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'h0);
    check("abort_flag", 32'(flag), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_seen), 32'(d0));

    issue("add_after", 3'b000, 8'd100, 8'd27, 16'h007F, 1'b0, 1);
    wait_quiet();
    repeat (2) @(posedge clk);
    #1;
    check("end_pending", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
